// File: rtl/print_pkg.sv
// rtl/print_pkg.sv - shared character constants and queue FSM state type for the print path
package print_pkg;

  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_WAKE = 8'hFF;

  typedef enum logic {
    S_CHAR,
    S_WRAP
  } pq_state_t;

endpackage

// File: rtl/print_fifo.sv
// rtl/print_fifo.sv - parameterised byte FIFO with registered pointers and occupancy count
import print_pkg::*;

module print_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset because the head is only shown when non-empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/print_queue.sv
// rtl/print_queue.sv - character queue feeding print_ctrl; PRINT_QUEUE_WRAP_EN adds LF injection at LINE_WIDTH
import print_pkg::*;

module print_queue #(
  parameter int DEPTH      = 16,
  parameter int LINE_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_char,
  output logic                     in_ready,
  output logic                     out_rdy,
  output logic [7:0]               out_char,
  input  logic                     out_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("print_queue: DEPTH must be a power of two in 2..256");
  end
  if (LINE_WIDTH < 1 || LINE_WIDTH > 255) begin : g_bad_width
    $error("print_queue: LINE_WIDTH must be in 1..255");
  end

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic       push;
  logic       pop;

  // Refusal depends only on the registered count, never on a same-cycle pop
  assign in_ready = ~fifo_full;
  assign push     = in_valid && ~fifo_full;

  print_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_char),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky overflow: any offer while full is a lost byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

`ifdef PRINT_QUEUE_WRAP_EN

  localparam logic [7:0] COL_LAST = 8'(LINE_WIDTH - 1);
  localparam logic [7:0] COL_SAT  = 8'(LINE_WIDTH);

  pq_state_t  state;
  pq_state_t  state_next;
  logic [7:0] col;
  logic       retire_char;
  logic       head_is_eol;
  logic       wrap_due;

  assign retire_char = (state == S_CHAR) && out_done && ~fifo_empty;
  assign head_is_eol = (head == CHAR_LF) || (head == CHAR_CR);
  assign wrap_due    = retire_char && ~head_is_eol && (col == COL_LAST);
  assign pop         = retire_char;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CHAR;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter S_WRAP after the last printable column, leave once the LF is sent
  always_comb begin
    state_next = state;
    case (state)
      S_CHAR:  if (wrap_due) state_next = S_WRAP;
      S_WRAP:  if (out_done) state_next = S_CHAR;
      default: state_next = S_CHAR;
    endcase
  end

  // Outputs: queue head while in S_CHAR, constant LF while in S_WRAP; all from registers
  always_comb begin
    out_rdy  = 1'b0;
    out_char = 8'h00;
    case (state)
      S_CHAR: begin
        out_rdy  = ~fifo_empty;
        out_char = fifo_empty ? 8'h00 : head;
      end
      S_WRAP: begin
        out_rdy  = 1'b1;
        out_char = CHAR_LF;
      end
      default: begin
        out_rdy  = 1'b0;
        out_char = 8'h00;
      end
    endcase
  end

  // Column tracking: EOL bytes reset it, a wrap parks it at LINE_WIDTH until the LF goes out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
    end else if (retire_char) begin
      if (head_is_eol) begin
        col <= '0;
      end else if (wrap_due) begin
        col <= COL_SAT;
      end else begin
        col <= col + 1'b1;
      end
    end else if ((state == S_WRAP) && out_done) begin
      col <= '0;
    end
  end

`else

  assign pop = out_done && ~fifo_empty;

  // Pass-through: the head byte is presented whenever the queue holds one
  always_comb begin
    out_rdy  = ~fifo_empty;
    out_char = fifo_empty ? 8'h00 : head;
  end

`endif

endmodule

// File: doc/print_queue.md
# print_queue

Character queue and line formatter directly upstream of `print_ctrl`. It accepts bytes from the keyboard/text source with a valid/ready handshake and buffers them in a small FIFO. It presents them one at a time on the `rdy`/`char` inputs of `print_ctrl` and retires each byte on that block's one-cycle `done` pulse. With auto-wrap compiled in, it injects a line feed once a printed line reaches the paper width.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `LINE_WIDTH`, 32: printable characters per printed line; 1..255.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  source offers `in_char` this cycle.
- `in_char`  in  8  byte to print.
- `in_ready`  out  1  queue can accept; equals `~full`.
- `out_rdy`  out  1  byte on `out_char` is ready; connect to `print_ctrl.rdy`.
- `out_char`  out  8  byte to send; connect to `print_ctrl.char`.
- `out_done`  in  1  one-cycle pulse meaning the current byte is sent; from `print_ctrl.done`.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when `in_valid` is asserted while full. Cleared only by `rst`.

## Operation
- **FIFO:**
  - Register array plus `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
  - `count` register; `full = (count == DEPTH)`, `empty = (count == 0)`.
  - A push occurs when `in_valid && in_ready`.
  - A pop occurs when the FSM retires a queue byte.
- **Simultaneous push and pop:**
  - When full, the push is refused because `in_ready` is low and does not look at the pop.
  - Otherwise both happen and `count` is unchanged.
- **FSM states:**
  - `S_CHAR`:
    - `out_rdy = ~empty`, `out_char = mem[rd_ptr]`.
    - On `out_done && ~empty`: pop and update the column.
    - Go to `S_WRAP` if a wrap is due; otherwise stay in `S_CHAR`.
  - `S_WRAP`:
    - `out_rdy = 1`, `out_char = 8'h0A`.
    - On `out_done`: `col <= 0`, go to `S_CHAR`.
    - No pop in this state.
  - `out_done` outside these conditions, or with `out_rdy` low, is ignored.
- **Column counter `col` (8 bits):**
  - Retiring 0x0A or 0x0D sets `col <= 0`.
  - Any other byte sets `col <= col + 1`.
  - A wrap is due when a non-LF/CR byte is retired with `col == LINE_WIDTH-1`. `col` then saturates at `LINE_WIDTH` until the LF is retired.
  - If the head after a wrap is an LF, it is still printed; there is no de-duplication.
- **Output stability:** `out_rdy` and `out_char` are held stable from the cycle `out_rdy` rises until the cycle `out_done` pulses. `print_ctrl` depends on this because it reloads its byte while `rdy` is high.
- **Reset:**
  - Pointers, `count`, `col` and `overflow` go to 0; FSM goes to `S_CHAR`.
  - Outputs: `out_rdy=0`, `out_char=8'h00`, `in_ready=1`, `overflow=0`.
  - Reset mid-byte discards the queue. No byte is replayed.

## Timing
- A push at edge k raises `count`; `out_rdy` is high from cycle k+1 when the queue was empty. Latency is one cycle.
- A retire at edge k (`out_done` high in cycle k-1..k) presents the next head or LF in cycle k+1. Back-to-back bytes therefore need no idle cycle.
- `in_ready` is combinational from the `count` register only. There is no path from `in_valid` or `out_done` to any output.
- After a pop from full, `in_ready` rises in the next cycle.
- `out_char` is a combinational read of the register array indexed by a registered pointer, muxed with the constant LF. It contains no logic from inputs.

## Configuration
- `PRINT_QUEUE_WRAP_EN` defined:
  - `col` and `S_WRAP` are present.
  - An LF is injected after `LINE_WIDTH` printable bytes.
- Undefined:
  - No column counter and no `S_WRAP`; the FSM reduces to `S_CHAR`.
  - Bytes pass through unmodified.
  - `LINE_WIDTH` is accepted but unused.

## Structure
- Shared package `print_pkg`:
  - `CHAR_LF = 8'h0A`, `CHAR_CR = 8'h0D`, `CHAR_WAKE = 8'hFF`.
  - `pq_state_t` enum `{S_CHAR, S_WRAP}`.
  - `print_ctrl` also imports this package.
- One sub-module, `print_fifo`: the parameterised storage, pointers and count with push/pop/full/empty.
- `print_queue` holds the FSM, the column logic and the sticky overflow flag.

## Test plan
- **Reset:** with `rst` high, then released → `out_rdy=0`, `in_ready=1`, `count=0`, `overflow=0`.
- **Single byte:** push 0x41 → `out_rdy=1`, `out_char=0x41` the next cycle and held across 3000 idle cycles. Pulse `out_done` → `out_rdy=0`, `count=0`.
- **Fill and overflow:** with DEPTH=16, push 17 bytes 0x30..0x40 with no `out_done` → `in_ready=0` after 16, `overflow=1`. Drain with 16 `out_done` pulses → outputs 0x30..0x3F in order; 0x40 is absent.
- **Simultaneous events:**
  - Full, with push and `out_done` in the same cycle → push refused, `count=15`.
  - `count=5`, with push and pop together → `count` stays 5.
- **Wrap (WRAP_EN, LINE_WIDTH=4):** push "ABCDE" → output sequence A,B,C,D,0x0A,E. Push "AB\nCD" → no injected LF.
- **Reset mid-operation:** 6 bytes queued, `rst` pulsed while `out_rdy=1` → `count=0`, `out_rdy=0`. Then push 0x5A → 0x5A is the next byte presented.
